// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU instruction/data memory subsystem.
// Imported by cpu_memsys; defines the data FSM states and the RW encoding.
package cpu_mem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAITING = 2'd1,
      DONE    = 2'd2
   } state_e;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   localparam int DW_DEF   = 16;
   localparam int IAW_DEF  = 7;
   localparam int DAW_DEF  = 7;
   localparam int WAIT_DEF = 0;

endpackage

// File: rtl/mem_1r1w.sv
// Synchronous RAM with one write port and one registered read port.
// A read and a write to the same address in one cycle return the old word.
module mem_1r1w #(
   parameter int W  = 16,
   parameter int AW = 7
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [W-1:0]  rdata_o
);

   logic [W-1:0] mem_q [0:(1<<AW)-1];
   logic [W-1:0] rdata_q;

   // NOTE: the array and its read register carry no reset so the storage maps onto
   // RAM macros; the owner masks rdata_o until a valid read has happened.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make the read sample the pre-write contents,
      // which is what gives read-before-write on a same-address collision.
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_memsys.sv
// Instruction/data memory subsystem: IMEM fetched every cycle with a load port,
// DMEM behind a request/ready handshake with WAIT extra cycles, sticky range error.
module cpu_memsys
   import cpu_mem_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int IAW  = IAW_DEF,
   parameter int DAW  = DAW_DEF,
   parameter int WAIT = WAIT_DEF
) (
   input  logic           CK,
   input  logic           RST,
   input  logic [15:0]    IA,
   output logic [DW-1:0]  ID,
   input  logic [15:0]    DA,
   input  logic [DW-1:0]  DD_I,
   output logic [DW-1:0]  DD_O,
   input  logic           RW,
   input  logic           DREQ,
   output logic           DRDY,
   input  logic           LD_EN,
   input  logic [IAW-1:0] LD_A,
   input  logic [DW-1:0]  LD_D,
   output logic           ERR
);

   generate
      if (WAIT < 0 || WAIT > 15) begin : g_bad_wait
         $fatal(1, "cpu_memsys: WAIT must be in 0..15");
      end
   endgenerate

   localparam logic [3:0] WAIT_M1 = 4'((WAIT > 0) ? WAIT - 1 : 0);

   state_e         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [DAW-1:0] addr_q, addr_d;
   logic           oor_q, oor_d;
   logic           rw_q, rw_d;
   logic [DW-1:0]  wdata_q, wdata_d;
   logic           drdy_q, drdy_d;
   logic           err_q, err_d;
   logic           ddo_ok_q, ddo_ok_d;
   logic           fetch_ok_q;

   logic           ia_oor, da_oor;
   logic           dmem_we, dmem_re;
   logic [DW-1:0]  imem_rdata, dmem_rdata;

   assign ia_oor = (IA >> IAW) != 16'd0;
   assign da_oor = (DA >> DAW) != 16'd0;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves
      // a signal unassigned and no latch is inferred.
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      oor_d    = oor_q;
      rw_d     = rw_q;
      wdata_d  = wdata_q;
      drdy_d   = 1'b0;
      err_d    = err_q | ia_oor;
      ddo_ok_d = ddo_ok_q;
      dmem_we  = 1'b0;
      dmem_re  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (DREQ) begin
               addr_d  = DA[DAW-1:0];
               oor_d   = da_oor;
               rw_d    = RW;
               wdata_d = DD_I;
               cnt_d   = WAIT_M1;
               state_d = (WAIT > 0) ? WAITING : DONE;
            end
         end
         WAITING: begin
            if (cnt_q == 4'd0) state_d = DONE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         DONE: begin
            // The access commits only on this edge, so a reset earlier discards it.
            drdy_d  = 1'b1;
            state_d = IDLE;
            err_d   = err_q | ia_oor | oor_q;
            if (rw_q == RW_READ) begin
               ddo_ok_d = !oor_q;
               dmem_re  = !oor_q;
            end else begin
               dmem_we  = !oor_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CK or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         addr_q     <= '0;
         oor_q      <= 1'b0;
         rw_q       <= RW_READ;
         wdata_q    <= '0;
         drdy_q     <= 1'b0;
         err_q      <= 1'b0;
         ddo_ok_q   <= 1'b0;
         fetch_ok_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         oor_q      <= oor_d;
         rw_q       <= rw_d;
         wdata_q    <= wdata_d;
         drdy_q     <= drdy_d;
         err_q      <= err_d;
         ddo_ok_q   <= ddo_ok_d;
         fetch_ok_q <= !ia_oor;
      end
   end

   mem_1r1w #(.W(DW), .AW(IAW)) u_imem (
      .clk     (CK),
      .we_i    (LD_EN),
      .waddr_i (LD_A),
      .wdata_i (LD_D),
      .re_i    (1'b1),
      .raddr_i (IA[IAW-1:0]),
      .rdata_o (imem_rdata)
   );

   mem_1r1w #(.W(DW), .AW(DAW)) u_dmem (
      .clk     (CK),
      .we_i    (dmem_we),
      .waddr_i (addr_q),
      .wdata_i (wdata_q),
      .re_i    (dmem_re),
      .raddr_i (addr_q),
      .rdata_o (dmem_rdata)
   );

   // Masking keeps outputs at zero after reset and for out-of-range accesses.
   assign ID   = fetch_ok_q ? imem_rdata : '0;
   assign DD_O = ddo_ok_q   ? dmem_rdata : '0;
   assign DRDY = drdy_q;
   assign ERR  = err_q;

endmodule
